// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Eight-source, rising-edge triggered interrupt controller with fixed priority
// (bit 0 highest). It presents one request at a time to the hazard control
// unit, waits for the acknowledge state, and then stays in service until a
// return-from-interrupt pulse. All registers change on the falling clock edge
// so that they line up with the pipeline control FSM.
//
// Ports
//   clock                    : single clock, registers update on falling edge
//   nreset                   : asynchronous active-low reset
//   irq_in[7:0]              : interrupt sources, rising-edge triggered
//   control_state[3:0]       : hazard control state, 4'h2 = interrupt accepted
//   reti                     : one-cycle return-from-interrupt pulse
//   cfg_we                   : config write strobe
//   cfg_addr[1:0]            : config register select
//   cfg_wdata[15:0]          : config write data
//   cfg_rdata[15:0]          : combinational read of the selected register
//   interrupt                : request to the hazard control unit
//   interrupt_vector_address : handler address, valid while interrupt=1
//   in_service               : handler executing
//   active_id[2:0]           : latched source index
//
// Config map
//   0 : mask[7:0]                        (R/W)
//   1 : vec_base[13:0]                   (R/W)
//   2 : pending[7:0]                     (read, write-1-to-clear)
//   3 : {ie[15], in_service[14], id[2:0]} (read, bit 15 writes ie)
// -----------------------------------------------------------------------------
module interrupt_controller (
    input  logic        clock,
    input  logic        nreset,
    input  logic [7:0]  irq_in,
    input  logic [3:0]  control_state,
    input  logic        reti,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [15:0] cfg_rdata,
    output logic        interrupt,
    output logic [13:0] interrupt_vector_address,
    output logic        in_service,
    output logic [2:0]  active_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } ctrlState_t;

    localparam logic [3:0] ACCEPT_STATE = 4'h2;

    ctrlState_t  state_q, state_d;
    logic [7:0]  irqPrev_q;
    logic [7:0]  pending_q, pending_d;
    logic [7:0]  mask_q, mask_d;
    logic [13:0] vecBase_q, vecBase_d;
    logic        ie_q, ie_d;
    logic [2:0]  activeId_q, activeId_d;
    logic [13:0] vector_q, vector_d;

    logic [7:0]  eligible;
    logic        anyEligible;
    logic [2:0]  winnerId;
    logic [7:0]  risingEdges;
    logic        ackNow;

    assign risingEdges = irq_in & ~irqPrev_q;
    assign eligible    = pending_q & mask_q;
    assign anyEligible = |eligible;
    assign ackNow      = (state_q == REQUEST) && (control_state == ACCEPT_STATE);

    // Fixed priority encoder: scanning from the top down leaves the lowest
    // set index as the final assignment, so bit 0 wins.
    always_comb begin
        winnerId = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) begin
                winnerId = 3'(i);
            end
        end
    end

    // Next-state and register update logic. Config writes are applied first,
    // FSM side effects override them, and new source edges are OR-ed in last
    // so that a set always wins over a same-cycle clear. The vector is
    // captured when the request is raised so it stays stable even if
    // vec_base is rewritten while the request is outstanding.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        mask_d     = mask_q;
        vecBase_d  = vecBase_q;
        ie_d       = ie_q;
        activeId_d = activeId_q;
        vector_d   = vector_q;

        if (cfg_we) begin
            case (cfg_addr)
                2'd0:    mask_d    = cfg_wdata[7:0];
                2'd1:    vecBase_d = cfg_wdata[13:0];
                2'd2:    pending_d = pending_q & ~cfg_wdata[7:0];
                default: ie_d      = cfg_wdata[15];
            endcase
        end

        case (state_q)
            IDLE: begin
                if (ie_q && anyEligible) begin
                    activeId_d = winnerId;
                    vector_d   = vecBase_q + {9'd0, winnerId, 2'b00};
                    state_d    = REQUEST;
                end
            end
            REQUEST: begin
                if (ackNow) begin
                    pending_d[activeId_q] = 1'b0;
                    ie_d                  = 1'b0;
                    state_d               = SERVICE;
                end
            end
            SERVICE: begin
                if (reti) begin
                    ie_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pending_d = pending_d | risingEdges;
    end

    // State register, falling-edge clocked with asynchronous reset so that
    // interrupt and in_service drop the moment nreset goes low.
    always_ff @(negedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            irqPrev_q  <= 8'd0;
            pending_q  <= 8'd0;
            mask_q     <= 8'd0;
            vecBase_q  <= 14'd0;
            ie_q       <= 1'b0;
            activeId_q <= 3'd0;
            vector_q   <= 14'd0;
        end else begin
            state_q    <= state_d;
            irqPrev_q  <= irq_in;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            vecBase_q  <= vecBase_d;
            ie_q       <= ie_d;
            activeId_q <= activeId_d;
            vector_q   <= vector_d;
        end
    end

    // Outputs decode straight from the state register.
    assign interrupt                = (state_q == REQUEST);
    assign in_service               = (state_q == SERVICE);
    assign active_id                = activeId_q;
    assign interrupt_vector_address = interrupt ? vector_q : 14'd0;

    // Config read mux; unused bits read as zero.
    always_comb begin
        cfg_rdata = 16'd0;
        case (cfg_addr)
            2'd0:    cfg_rdata = {8'd0, mask_q};
            2'd1:    cfg_rdata = {2'd0, vecBase_q};
            2'd2:    cfg_rdata = {8'd0, pending_q};
            default: cfg_rdata = {ie_q, in_service, 11'd0, activeId_q};
        endcase
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Directed testbench for interrupt_controller. Inputs change 1 time unit after
// each falling (active) clock edge; outputs are checked there too, well away
// from the next active edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

    logic        clock;
    logic        nreset;
    logic [7:0]  irq_in;
    logic [3:0]  control_state;
    logic        reti;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        interrupt;
    logic [13:0] interrupt_vector_address;
    logic        in_service;
    logic [2:0]  active_id;

    int compareCount  = 0;
    int mismatchCount = 0;

    interrupt_controller dut (
        .clock                    (clock),
        .nreset                   (nreset),
        .irq_in                   (irq_in),
        .control_state            (control_state),
        .reti                     (reti),
        .cfg_we                   (cfg_we),
        .cfg_addr                 (cfg_addr),
        .cfg_wdata                (cfg_wdata),
        .cfg_rdata                (cfg_rdata),
        .interrupt                (interrupt),
        .interrupt_vector_address (interrupt_vector_address),
        .in_service               (in_service),
        .active_id                (active_id)
    );

    // Free-running clock, period 10; falling edges at 10, 20, 30 ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One compare, counted and reported on failure.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance past the next active edge.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // Config write occupying one active edge.
    task automatic applyStimulus(input logic [1:0] addr, input logic [15:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Select a config register and compare the combinational read.
    task automatic checkReg(input string tag, input logic [1:0] addr,
                            input logic [15:0] expected);
        cfg_addr = addr;
        #1;
        checkOutput(tag, cfg_rdata, expected);
    endtask

    // Snapshot of the request-side outputs.
    task automatic checkReq(input string tag, input logic expIrq,
                            input logic [13:0] expVec, input logic [2:0] expId);
        checkOutput({tag, "_irq"}, {15'd0, interrupt}, {15'd0, expIrq});
        checkOutput({tag, "_vec"}, {2'd0, interrupt_vector_address}, {2'd0, expVec});
        checkOutput({tag, "_id"},  {13'd0, active_id}, {13'd0, expId});
    endtask

    // Acknowledge then return, each one edge.
    task automatic ackAndReturn();
        control_state = 4'h2;
        tick();
        control_state = 4'h0;
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    initial begin
        nreset        = 1'b1;
        irq_in        = 8'd0;
        control_state = 4'h0;
        reti          = 1'b0;
        cfg_we        = 1'b0;
        cfg_addr      = 2'd0;
        cfg_wdata     = 16'd0;

        // Reset state
        #2 nreset = 1'b0;
        #2;
        checkReq("rst", 1'b0, 14'h0000, 3'd0);
        checkOutput("rst_insvc", {15'd0, in_service}, 16'd0);
        checkReg("rst_mask", 2'd0, 16'h0000);
        checkReg("rst_base", 2'd1, 16'h0000);
        checkReg("rst_pend", 2'd2, 16'h0000);
        checkReg("rst_stat", 2'd3, 16'h0000);
        tick();
        nreset = 1'b1;

        // Basic request: source 3, base 0x0100
        applyStimulus(2'd0, 16'h00FF);
        applyStimulus(2'd1, 16'h0100);
        applyStimulus(2'd3, 16'h8000);
        checkReg("cfg_mask", 2'd0, 16'h00FF);
        checkReg("cfg_stat", 2'd3, 16'h8000);
        irq_in = 8'h08;
        tick();
        checkReq("lat_k", 1'b0, 14'h0000, 3'd0);
        checkReg("lat_pend", 2'd2, 16'h0008);
        tick();
        checkReq("src3", 1'b1, 14'h010C, 3'd3);
        checkReg("src3_stat", 2'd3, 16'h8003);

        // Committed request survives W1C, mask and ie writes; reti ignored
        applyStimulus(2'd2, 16'h0008);
        checkReg("w1c_pend", 2'd2, 16'h0000);
        applyStimulus(2'd0, 16'h0000);
        applyStimulus(2'd3, 16'h0000);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        checkReq("commit", 1'b1, 14'h010C, 3'd3);
        applyStimulus(2'd0, 16'h00FF);

        // Acknowledge
        control_state = 4'h2;
        tick();
        control_state = 4'h0;
        checkReq("ack", 1'b0, 14'h0000, 3'd3);
        checkReg("ack_stat", 2'd3, 16'h4003);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        checkReg("reti_stat", 2'd3, 16'h8003);
        checkOutput("reti_irq", {15'd0, interrupt}, 16'd0);
        irq_in = 8'h00;
        tick();

        // Priority: sources 5 and 1 together
        irq_in = 8'h22;
        tick();
        checkReg("pri_pend", 2'd2, 16'h0022);
        tick();
        checkReq("pri1", 1'b1, 14'h0104, 3'd1);
        ackAndReturn();
        tick();
        checkReq("pri5", 1'b1, 14'h0114, 3'd5);

        // New edge during service is held until reti
        control_state = 4'h2;
        tick();
        control_state = 4'h0;
        checkReg("svc_pend0", 2'd2, 16'h0000);
        irq_in = 8'h26;
        tick();
        checkReg("svc_pend", 2'd2, 16'h0004);
        tick();
        tick();
        checkOutput("svc_noirq", {15'd0, interrupt}, 16'd0);
        checkOutput("svc_insvc", {15'd0, in_service}, 16'd1);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        checkOutput("svc_idle", {15'd0, interrupt}, 16'd0);
        tick();
        checkReq("svc_next", 1'b1, 14'h0108, 3'd2);
        ackAndReturn();
        irq_in = 8'h00;
        tick();

        // Vector wrap
        applyStimulus(2'd1, 16'h3FFC);
        irq_in = 8'h80;
        tick();
        tick();
        checkReq("wrap", 1'b1, 14'h0018, 3'd7);
        ackAndReturn();
        irq_in = 8'h00;
        tick();

        // Masked source, then unmask, then async reset mid-request
        applyStimulus(2'd0, 16'h0000);
        applyStimulus(2'd1, 16'h0000);
        irq_in = 8'h04;
        tick();
        tick();
        checkReg("msk_pend", 2'd2, 16'h0004);
        checkOutput("msk_noirq", {15'd0, interrupt}, 16'd0);
        applyStimulus(2'd0, 16'h0004);
        checkOutput("msk_wait", {15'd0, interrupt}, 16'd0);
        tick();
        checkReq("unmask", 1'b1, 14'h0008, 3'd2);
        #2 nreset = 1'b0;
        #1;
        checkReq("arst", 1'b0, 14'h0000, 3'd0);
        checkReg("arst_pend", 2'd2, 16'h0000);
        checkReg("arst_mask", 2'd0, 16'h0000);
        tick();
        nreset = 1'b1;

        // Source held high across reset release counts as an edge
        applyStimulus(2'd0, 16'h00FF);
        checkReg("hold_pend", 2'd2, 16'h0004);
        applyStimulus(2'd3, 16'h8000);
        tick();
        checkReq("hold", 1'b1, 14'h0008, 3'd2);

        // Same-edge set and W1C of one bit: set wins
        irq_in = 8'h00;
        tick();
        irq_in = 8'h10;
        applyStimulus(2'd2, 16'h0010);
        checkReg("setwin", 2'd2, 16'h0014);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have port clock, input, 1: single clock; all registers update on its falling edge, matching the pipeline control FSM.
REQ-002 SHALL have port nreset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port irq_in, input, 8: interrupt sources, synchronous to clock, rising-edge triggered; bit 0 is highest priority.
REQ-004 SHALL have port control_state, input, 4: hazard control state; value 4'h2 = interrupt accepted.
REQ-005 SHALL have port reti, input, 1: one-cycle pulse marking return-from-interrupt.
REQ-006 SHALL have port cfg_we, input, 1: config write strobe.
REQ-007 SHALL have port cfg_addr, input, 2: config register select.
REQ-008 SHALL have port cfg_wdata, input, 16: config write data.
REQ-009 SHALL have port cfg_rdata, output, 16: combinational read of the register selected by cfg_addr.
REQ-010 SHALL have port interrupt, output, 1: request to hazard control unit.
REQ-011 SHALL have port interrupt_vector_address, output, 14: handler address, valid while interrupt=1.
REQ-012 SHALL have port in_service, output, 1: handler executing.
REQ-013 SHALL have port active_id, output, 3: latched source index.

Function
REQ-014 Config map SHALL be: 0 = mask[7:0] (R/W); 1 = vec_base[13:0] (R/W); 2 = pending[7:0] (read; write-1-to-clear); 3 = {ie at bit15, in_service at bit14, active_id at bits 2:0} (read; write to bit15 sets/clears ie). Unused read bits SHALL be 0.
REQ-015 Edge detect SHALL keep irq_prev; pending[i] set on the clock where irq_in[i]=1 and irq_prev[i]=0.
REQ-016 Same-cycle set and clear of one pending bit (cfg W1C or ack) SHALL resolve with set winning.
REQ-017 FSM SHALL have three states: IDLE, REQUEST, SERVICE.
REQ-018 IDLE: when ie=1 and (pending & mask)!=0, SHALL latch active_id = lowest set index of (pending & mask) and move to REQUEST.
REQ-019 REQUEST: interrupt SHALL be 1. interrupt_vector_address SHALL be (vec_base + {active_id,2'b00}) mod 2^14 and SHALL be held stable.
REQ-020 REQUEST: on control_state==4'h2 the FSM SHALL clear pending[active_id], set in_service, clear ie, and move to SERVICE; interrupt SHALL drop on that same edge.
REQ-021 REQUEST is committed: later mask changes, ie writes, or W1C of the latched bit SHALL NOT withdraw the request.
REQ-022 SERVICE: interrupt SHALL be 0. New edges SHALL still set pending bits. On reti=1 the FSM SHALL clear in_service, set ie, and return to IDLE.
REQ-023 reti outside SERVICE SHALL be ignored.
REQ-024 Latency: a source edge sampled at edge k with ie=1, unmasked, in IDLE SHALL give interrupt=1 after edge k+1.
REQ-025 Vector arithmetic SHALL wrap modulo 2^14 with no overflow flag.
REQ-026 While interrupt=0, interrupt_vector_address SHALL be 0.

Reset
REQ-027 nreset=0 SHALL asynchronously force: state IDLE, interrupt 0, interrupt_vector_address 0, in_service 0, active_id 0, mask 0, vec_base 0, pending 0, ie 0, irq_prev 0.
REQ-028 Reset asserted in REQUEST or SERVICE SHALL drop interrupt and in_service immediately, without waiting for a clock.
REQ-029 A source held high at reset release SHALL register as an edge on the first clock.

Verification
REQ-030 Setup: mask=8'hFF, vec_base=14'h0100, ie=1. Stimulus: irq_in[3] rises. Required: interrupt=1 two edges later, vector=14'h010C, active_id=3.
REQ-031 Setup: irq_in[5] and irq_in[1] rise together. Required: active_id=1, vector=base+4. After ack and reti, a second request follows with active_id=5.
REQ-032 Setup: in REQUEST. Stimulus: control_state=4'h2. Required: interrupt=0, in_service=1, pending[id]=0, ie=0. A new edge during SERVICE raises no request until reti.
REQ-033 Setup: vec_base=14'h3FFC. Stimulus: irq_in[7] rises. Required: vector=14'h0018 (wrap).
REQ-034 Setup: mask=8'h00. Stimulus: irq_in[2] rises. Required: pending=8'h04, no interrupt. After writing mask=8'h04, interrupt asserts. Asserting nreset mid-REQUEST clears interrupt asynchronously and sets pending=0.
